// File: rtl/square_move_scheduler_pkg.sv
// Shared types and constants for the square move scheduler slice.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package square_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int X_MAX_DEF       = 640;
  localparam int Y_MAX_DEF       = 480;
  localparam int SQUARE_SIZE_DEF = 30;
  localparam int STEP_DEF        = 5;

  // Bit positions inside one square's 4-bit button nibble {up,left,down,right}
  localparam int BTN_U = 3;
  localparam int BTN_L = 2;
  localparam int BTN_D = 1;
  localparam int BTN_R = 0;

  localparam int COORD_W = 10;
  localparam int POS_W   = 2 * COORD_W;

  function automatic logic [COORD_W-1:0] pos_x(input logic [POS_W-1:0] p);
    return p[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] pos_y(input logic [POS_W-1:0] p);
    return p[POS_W-1:COORD_W];
  endfunction

  function automatic logic [POS_W-1:0] pack_pos(input logic [COORD_W-1:0] y,
                                                input logic [COORD_W-1:0] x);
    return {y, x};
  endfunction

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/square_move_scheduler_if.sv
// Bundles the frame strobe, buttons and position/status outputs of the scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are strobes or levels with no ready.
interface square_move_scheduler_if #(
  parameter int NUM_SQ = 2
);
  logic                  refresh_tick;
  logic                  run;
  logic [4*NUM_SQ-1:0]   btn;
  logic [20*NUM_SQ-1:0]  pos;
  logic                  upd_valid;
  logic [1:0]            upd_idx;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;

  // Driver side: frame timing and button sources
  modport master (
    output refresh_tick, run, btn,
    input  pos, upd_valid, upd_idx, busy, frame_done, overrun
  );

  // Scheduler side
  modport slave (
    input  refresh_tick, run, btn,
    output pos, upd_valid, upd_idx, busy, frame_done, overrun
  );
endinterface

// File: rtl/square_move_scheduler_step_clamp.sv
// Computes one square's next position from its buttons, clamped to the display.
// Latency: combinational.
// Backpressure: none.
module square_step_clamp
  import square_pkg::*;
#(
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MAX       = Y_MAX_DEF,
  parameter int SQUARE_SIZE = SQUARE_SIZE_DEF,
  parameter int STEP        = STEP_DEF
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [3:0]         btn,
  output logic [COORD_W-1:0] nx,
  output logic [COORD_W-1:0] ny
);
  localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(X_MAX - SQUARE_SIZE);
  localparam logic [COORD_W-1:0] X_THR  = COORD_W'(X_MAX - SQUARE_SIZE - STEP);
  localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(Y_MAX - SQUARE_SIZE);
  localparam logic [COORD_W-1:0] Y_THR  = COORD_W'(Y_MAX - SQUARE_SIZE - STEP);

  // Opposing keys cancel; a single key steps toward its border and saturates there
  always_comb begin
    nx = x;
    ny = y;
    if (btn[BTN_L] && !btn[BTN_R]) begin
      nx = (x > STEP_C) ? (x - STEP_C) : '0;
    end else if (btn[BTN_R] && !btn[BTN_L]) begin
      nx = (x < X_THR) ? (x + STEP_C) : X_LIM;
    end
    if (btn[BTN_U] && !btn[BTN_D]) begin
      ny = (y > STEP_C) ? (y - STEP_C) : '0;
    end else if (btn[BTN_D] && !btn[BTN_U]) begin
      ny = (y < Y_THR) ? (y + STEP_C) : Y_LIM;
    end
  end
endmodule

// File: rtl/square_move_scheduler.sv
// Per-frame scheduler: updates each square in turn through one shared step/clamp path.
// Latency: tick at edge k -> frame_done high in cycle k+2*NUM_SQ+1; one upd_valid per square.
// Backpressure: none; ticks arriving while busy are dropped and flag sticky overrun.
// Optional build macro COLLISION_BLOCK_EN: discard moves that would overlap another square.
module square_move_scheduler
  import square_pkg::*;
#(
  parameter int NUM_SQ       = 2,
  parameter int X_MAX        = X_MAX_DEF,
  parameter int Y_MAX        = Y_MAX_DEF,
  parameter int SQUARE_SIZE  = SQUARE_SIZE_DEF,
  parameter int STEP         = STEP_DEF,
  parameter int INIT_X       = 300,
  parameter int INIT_Y       = 220,
  parameter int INIT_SPACING = 60
) (
  input logic clk,
  input logic reset,
  square_move_scheduler_if.slave bus
);
  state_t             state;
  logic [1:0]         idx;
  logic [COORD_W-1:0] sq_x [NUM_SQ];
  logic [COORD_W-1:0] sq_y [NUM_SQ];
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [COORD_W-1:0] step_x, step_y;
  logic [3:0]         cur_btn;
  logic               blocked;
  logic               upd_valid_q;
  logic [1:0]         upd_idx_q;
  logic               frame_done_q;
  logic               overrun_q;

  // Route the square being processed (and its buttons) into the shared datapath
  always_comb begin
    cur_x   = sq_x[0];
    cur_y   = sq_y[0];
    cur_btn = bus.btn[3:0];
    for (int i = 1; i < NUM_SQ; i++) begin
      if (idx == 2'(i)) begin
        cur_x   = sq_x[i];
        cur_y   = sq_y[i];
        cur_btn = bus.btn[4*i +: 4];
      end
    end
  end

  square_step_clamp #(
    .X_MAX       (X_MAX),
    .Y_MAX       (Y_MAX),
    .SQUARE_SIZE (SQUARE_SIZE),
    .STEP        (STEP)
  ) u_step_clamp (
    .x   (cur_x),
    .y   (cur_y),
    .btn (cur_btn),
    .nx  (step_x),
    .ny  (step_y)
  );

`ifdef COLLISION_BLOCK_EN
  // Reject the candidate if it overlaps any other square; earlier squares are already updated
  always_comb begin
    blocked = 1'b0;
    for (int j = 0; j < NUM_SQ; j++) begin
      if ((idx != 2'(j)) &&
          (abs_diff(cand_x, sq_x[j]) < COORD_W'(SQUARE_SIZE)) &&
          (abs_diff(cand_y, sq_y[j]) < COORD_W'(SQUARE_SIZE))) begin
        blocked = 1'b1;
      end
    end
  end
`else
  assign blocked = 1'b0;
`endif

  // Export every square's position as a packed {y,x} bus
  for (genvar g = 0; g < NUM_SQ; g++) begin : g_pos
    assign bus.pos[20*g +: 20] = pack_pos(sq_y[g], sq_x[g]);
  end

  assign bus.upd_valid  = upd_valid_q;
  assign bus.upd_idx    = upd_idx_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state != ST_IDLE);

  // Frame FSM: IDLE -> (CALC -> WRITE) per square -> DONE -> IDLE, with registered strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= 2'd0;
      cand_x       <= '0;
      cand_y       <= '0;
      upd_valid_q  <= 1'b0;
      upd_idx_q    <= 2'd0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUM_SQ; i++) begin
        sq_x[i] <= COORD_W'(INIT_X + i * INIT_SPACING);
        sq_y[i] <= COORD_W'(INIT_Y);
      end
    end else begin
      upd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.refresh_tick && (state != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (bus.refresh_tick && bus.run) begin
            idx   <= 2'd0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          cand_x <= step_x;
          cand_y <= step_y;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          for (int i = 0; i < NUM_SQ; i++) begin
            if ((idx == 2'(i)) && !blocked) begin
              sq_x[i] <= cand_x;
              sq_y[i] <= cand_y;
            end
          end
          upd_valid_q <= 1'b1;
          upd_idx_q   <= idx;
          if (idx == 2'(NUM_SQ - 1)) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= ST_CALC;
          end
        end
        default: begin
          frame_done_q <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_square_move_scheduler.sv
// Directed bench for square_move_scheduler with a queue-based update scoreboard.
// Latency: checks frame_done arrives five cycles after each accepted tick.
// Backpressure: exercises dropped ticks (overrun) and run-gated ticks.
module tb_square_move_scheduler;
  localparam int NSQ = 2;

  typedef struct {
    logic [1:0]  idx;
    logic [19:0] pos;
  } upd_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  square_move_scheduler_if #(.NUM_SQ(NSQ)) bus ();

  square_move_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  upd_t exp_q[$];
  upd_t mon_e;
  logic [9:0] mx [NSQ];
  logic [9:0] my [NSQ];

`ifdef COLLISION_BLOCK_EN
  localparam int EXP_COLL_X = 300;
`else
  localparam int EXP_COLL_X = 305;
`endif

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // One axis move: dec/inc keys, border lim (640 or 480), 30-pixel square, 5-pixel step
  function automatic logic [9:0] mv(input logic [9:0] v, input logic dec, input logic inc,
                                    input int lim);
    int r;
    r = int'(v);
    if (dec && !inc) r = (r > 5) ? r - 5 : 0;
    else if (inc && !dec) r = (r < lim - 35) ? r + 5 : lim - 30;
    return 10'(r);
  endfunction

  task automatic model_reset();
    mx[0] = 10'd300; mx[1] = 10'd360;
    my[0] = 10'd220; my[1] = 10'd220;
  endtask

  // Predict one frame and queue the expected commit of each square in index order
  task automatic model_frame(input logic [7:0] b);
    logic [9:0] cx, cy;
    logic blk;
    upd_t e;
    for (int i = 0; i < NSQ; i++) begin
      cx = mv(mx[i], b[4*i+2], b[4*i+0], 640);
      cy = mv(my[i], b[4*i+3], b[4*i+1], 480);
      blk = 1'b0;
`ifdef COLLISION_BLOCK_EN
      for (int j = 0; j < NSQ; j++)
        if (j != i && absd(cx, mx[j]) < 30 && absd(cy, my[j]) < 30) blk = 1'b1;
`endif
      if (!blk) begin
        mx[i] = cx;
        my[i] = cy;
      end
      e.idx = 2'(i);
      e.pos = {my[i], mx[i]};
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every committed update must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && bus.upd_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_upd: got idx %0d, expected no update", bus.upd_idx);
      end else begin
        mon_e = exp_q.pop_front();
        check("upd_idx", int'(bus.upd_idx), int'(mon_e.idx));
        check("upd_pos", int'(bus.pos[20*mon_e.idx +: 20]), int'(mon_e.pos));
      end
    end
  end

  // Issue a frame at the current negedge; optionally raise a second tick sampled at edge k+extra
  task automatic frame_ex(input logic [7:0] b, input int extra);
    int lat;
    bus.btn = b;
    bus.run = 1'b1;
    bus.refresh_tick = 1'b1;
    model_frame(b);
    @(posedge clk);
    #1 bus.refresh_tick = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1 bus.refresh_tick = (n + 1 == extra);
      @(negedge clk);
      if (bus.frame_done) begin
        lat = n;
        break;
      end
    end
    bus.refresh_tick = 1'b0;
    check("frame_latency", lat, 5);
  endtask

  function automatic int px(input int i);
    return int'(bus.pos[20*i +: 10]);
  endfunction

  function automatic int py(input int i);
    return int'(bus.pos[20*i+10 +: 10]);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen_busy, seen_done, oob;
    reset = 1'b1;
    bus.run = 1'b0;
    bus.refresh_tick = 1'b0;
    bus.btn = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_pos0", int'(bus.pos[19:0]), (220 << 10) | 300);
    check("rst_pos1", int'(bus.pos[39:20]), (220 << 10) | 360);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_upd_valid", int'(bus.upd_valid), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);

    // First frame: square 0 right
    frame_ex(8'h01, 0);
    check("f1_x0", px(0), 305);
    check("f1_pos1", int'(bus.pos[39:20]), (220 << 10) | 360);

    // Back to 300, then square 1 left to 330 to set up a near-overlap
    frame_ex(8'h04, 0);
    repeat (6) frame_ex(8'h40, 0);
    check("x1_at_330", px(1), 330);
    frame_ex(8'h01, 0);
    check("coll_x0", px(0), EXP_COLL_X);

    // Square 1 right into the right border clamp
    repeat (55) frame_ex(8'h10, 0);
    check("x1_605", px(1), 605);
    frame_ex(8'h10, 0);
    check("x1_clamp_610", px(1), 610);
    frame_ex(8'h10, 0);
    check("x1_hold_610", px(1), 610);

    // Square 0 left into the left border
    repeat (62) frame_ex(8'h04, 0);
    check("x0_clamp_0", px(0), 0);

    // Square 0 down into the bottom border
    repeat (45) frame_ex(8'h02, 0);
    check("y0_445", py(0), 445);
    frame_ex(8'h02, 0);
    check("y0_clamp_450", py(0), 450);
    frame_ex(8'h02, 0);
    check("y0_hold_450", py(0), 450);

    // Opposing keys cancel, diagonal moves both axes
    frame_ex(8'h01, 0);
    frame_ex(8'h05, 0);
    check("lr_cancel_x0", px(0), 5);
    frame_ex(8'h08, 0);
    frame_ex(8'h0A, 0);
    check("ud_cancel_y0", py(0), 445);
    frame_ex(8'h09, 0);
    check("diag_x0", px(0), 10);
    check("diag_y0", py(0), 440);

    // Tick with run low is ignored
    bus.run = 1'b0;
    bus.refresh_tick = 1'b1;
    @(posedge clk);
    #1 bus.refresh_tick = 1'b0;
    seen_busy = 0;
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.busy) seen_busy++;
      if (bus.frame_done) seen_done++;
    end
    check("norun_busy", seen_busy, 0);
    check("norun_frame_done", seen_done, 0);
    check("norun_overrun", int'(bus.overrun), 0);

    // Second tick two cycles into a frame is dropped and flags overrun
    frame_ex(8'h01, 2);
    check("ovr_flag", int'(bus.overrun), 1);
    check("ovr_x0", px(0), 15);
    repeat (8) @(negedge clk);
    check("ovr_no_extra", exp_q.size(), 0);

    // Reset during WRITE of square 1 aborts the frame
    bus.btn = 8'h11;
    bus.run = 1'b1;
    bus.refresh_tick = 1'b1;
    model_frame(8'h11);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1 bus.refresh_tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.frame_done) seen_done++;
    end
    check("abort_frame_done", seen_done, 0);
    check("abort_pos0", int'(bus.pos[19:0]), (220 << 10) | 300);
    check("abort_pos1", int'(bus.pos[39:20]), (220 << 10) | 360);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_overrun", int'(bus.overrun), 0);

    // Back-to-back frames every 6 cycles with random buttons
    oob = 0;
    for (int f = 0; f < 100; f++) begin
      frame_ex(8'($urandom_range(0, 255)), 0);
      for (int i = 0; i < NSQ; i++)
        if (px(i) > 610 || py(i) > 450) oob++;
    end
    check("rand_out_of_bounds", oob, 0);
    check("rand_overrun", int'(bus.overrun), 0);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
